// File: rtl/fifo_access_sched.sv
// Access scheduler for a 256x9 single-port FIFO store: arbitrates two writers and one
// reader onto one storage operation per cycle, tracks occupancy, sequences pointer clears.
module fifo_access_sched #(
    parameter int DW    = 9,
    parameter int AW    = 8,
    parameter int DEPTH = 256
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          wr0_req,
    input  logic [DW-1:0] wr0_data,
    output logic          wr0_gnt,
    input  logic          wr1_req,
    input  logic [DW-1:0] wr1_data,
    output logic          wr1_gnt,
    input  logic          rd_req,
    output logic          rd_gnt,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    output logic          fifo_rdptrclr,
    output logic          fifo_wrptrclr,
    output logic          fifo_rden,
    output logic          fifo_wren,
    output logic          fifo_rdinc,
    output logic          fifo_wrinc,
    output logic [DW-1:0] fifo_din,
    input  logic [DW-1:0] fifo_dout,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty,
    output logic          busy,
    output logic [1:0]    dbg_state
);

    // Handshake: a requester raises req with stable data and holds both until it sees
    // gnt in the same cycle; the transfer happens on the clock edge where req & gnt.
    typedef enum logic [1:0] {
        CLR_RD = 2'd0,
        CLR_WR = 2'd1,
        RUN    = 2'd2
    } state_e;

    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_CNT   = (AW+1)'(1);
    localparam logic        PRI_WR    = 1'b0;
    localparam logic        PRI_RD    = 1'b1;

    state_e      state_q, state_d;
    logic [AW:0] count_q, count_d;
    logic        rd_valid_q;
    logic        rw_pri_q, rw_pri_d;
    logic        wr_last_q, wr_last_d;   // 1: writer 1 was granted last
    logic        rd_elig, wr_elig, do_rd, do_wr, pick_wr0;

    assign full      = (count_q == DEPTH_CNT);
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign busy      = (state_q != RUN);
    assign rd_valid  = rd_valid_q;
    assign rd_data   = fifo_dout;
    assign dbg_state = state_q;

    assign rd_elig  = rd_req & ~empty;
    assign wr_elig  = (wr0_req | wr1_req) & ~full;
    assign pick_wr0 = wr0_req & (~wr1_req | wr_last_q);

    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        rw_pri_d      = rw_pri_q;
        wr_last_d     = wr_last_q;
        do_rd         = 1'b0;
        do_wr         = 1'b0;
        wr0_gnt       = 1'b0;
        wr1_gnt       = 1'b0;
        rd_gnt        = 1'b0;
        fifo_rdptrclr = 1'b0;
        fifo_wrptrclr = 1'b0;
        case (state_q)
            CLR_RD: begin
                fifo_rdptrclr = 1'b1;
                state_d       = CLR_WR;
            end
            CLR_WR: begin
                fifo_wrptrclr = 1'b1;
                count_d       = '0;
                state_d       = RUN;
            end
            RUN: begin
                if (flush) begin
                    state_d = CLR_RD;
                end else begin
                    do_rd = rd_elig & (~wr_elig | (rw_pri_q == PRI_RD));
                    do_wr = wr_elig & ~do_rd;
                    // Whichever side wins, the other side gets priority next time.
                    if (do_rd || do_wr) begin
                        rw_pri_d = do_rd ? PRI_WR : PRI_RD;
                    end
                    if (do_wr) begin
                        wr0_gnt   = pick_wr0;
                        wr1_gnt   = ~pick_wr0;
                        wr_last_d = ~pick_wr0;
                        count_d   = count_q + ONE_CNT;
                    end else if (do_rd) begin
                        rd_gnt  = 1'b1;
                        count_d = count_q - ONE_CNT;
                    end
                end
            end
            default: state_d = CLR_RD;
        endcase
    end

    assign fifo_wren  = wr0_gnt | wr1_gnt;
    assign fifo_wrinc = fifo_wren;
    assign fifo_rden  = rd_gnt;
    assign fifo_rdinc = fifo_rden;
    assign fifo_din   = wr0_gnt ? wr0_data : wr1_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= CLR_RD;
            count_q    <= '0;
            rd_valid_q <= 1'b0;
            rw_pri_q   <= PRI_WR;
            wr_last_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            rd_valid_q <= rd_gnt;
            rw_pri_q   <= rw_pri_d;
            wr_last_q  <= wr_last_d;
        end
    end

endmodule

// File: doc/fifo_access_sched.md
Name: fifo_access_sched

Overview:
Scheduler and arbiter for the 256x9 single-port FIFO storage block. It shares the storage between two write requesters and one read requester, and issues at most one storage operation per cycle. It also generates the storage control strobes, tracks occupancy and full/empty, and sequences pointer clears at reset and on flush.

Parameters:
DW, 9, data width of requester and storage data
AW, 8, storage pointer width
DEPTH, 256, storage entries (2**AW)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
flush  in  1  single-cycle flush request
wr0_req  in  1  write request, requester 0
wr0_data  in  DW  write data, requester 0
wr0_gnt  out  1  write grant, requester 0
wr1_req  in  1  write request, requester 1
wr1_data  in  DW  write data, requester 1
wr1_gnt  out  1  write grant, requester 1
rd_req  in  1  read request
rd_gnt  out  1  read grant
rd_valid  out  1  read data valid
rd_data  out  DW  read data (passthrough of fifo_dout)
fifo_rdptrclr  out  1  storage read-pointer clear
fifo_wrptrclr  out  1  storage write-pointer clear
fifo_rden  out  1  storage read enable
fifo_wren  out  1  storage write enable
fifo_rdinc  out  1  storage read increment
fifo_wrinc  out  1  storage write increment
fifo_din  out  DW  storage write data
fifo_dout  in  DW  storage registered read data
count  out  AW+1  occupancy, 0..DEPTH
full  out  1  count==DEPTH
empty  out  1  count==0
busy  out  1  clear sequence in progress

Behaviour:
- Reset is rst, synchronous, active-high; clock is clk.
- Reset values: state=CLR_RD, count=0, empty=1, full=0, busy=1, rd_valid=0, rw_pri=write, wr_last=wr1. All grants and strobes are 0 except fifo_rdptrclr in CLR_RD.
- FSM states:
  - CLR_RD: fifo_rdptrclr=1, no grants. Next state CLR_WR.
  - CLR_WR: fifo_wrptrclr=1, no grants, count<=0. Next state RUN.
  - RUN: arbitration. If flush=1, no grants this cycle and next state is CLR_RD.
- Pointer clears are issued in separate cycles because storage priority is rdptrclr > wrptrclr > rden > wren. The block never asserts two of these four strobes in the same cycle.
- busy = (state != RUN). flush is ignored while busy.
- Eligibility in RUN:
  - read eligible = rd_req & !empty
  - write eligible = (wr0_req | wr1_req) & !full
- Grants are combinational, same cycle as req. A transfer occurs on req & gnt, and the requester holds data/req until granted.
- Read vs write priority, when both are eligible:
  - Grant the side named by rw_pri, then toggle rw_pri.
  - If only one side is eligible, grant it and set rw_pri to the other side.
- Write arbitration, when both writers request: grant the writer != wr_last. wr_last updates on every write grant.
- Strobes:
  - fifo_wren = wr0_gnt | wr1_gnt; fifo_wrinc = fifo_wren.
  - fifo_din = wr0_data if wr0_gnt else wr1_data.
  - fifo_rden = rd_gnt; fifo_rdinc = fifo_rden.
- Latency: rd_valid is registered and equals rd_gnt delayed 1 cycle. rd_data = fifo_dout and is meaningful only when rd_valid=1 (storage may drive z otherwise).
- count: +1 on write grant, -1 on read grant. Both never occur in the same cycle. No overflow or underflow is possible by construction.
- full/empty are combinational from count. At count==DEPTH a write is never granted; at count==0 a read is never granted.
- Storage pointers wrap modulo DEPTH. The scheduler holds no pointers and is wrap-agnostic.
- Flush with a read granted in the previous cycle: rd_valid still asserts for that read. Data is discarded only by the pointer clear.
- rst mid-operation: returns to CLR_RD next edge with all reset values, including rd_valid=0.

Test Plan:
- Reset: rst high 2 cycles, then low -> fifo_rdptrclr=1 in cycle 1, fifo_wrptrclr=1 in cycle 2, busy=0 from cycle 3; count=0, empty=1, no grants while busy.
- Fill: wr0_req held with data=0..255 -> 256 consecutive wr0_gnt; count reaches 256, full=1, wr0_gnt=0 on the 257th cycle.
- Drain order: after fill, rd_req held -> 256 rd_gnt; rd_valid 1 cycle after each, rd_data 0..255 in order; empty=1 and rd_gnt=0 afterwards.
- Contention: count=10, wr0_req, wr1_req and rd_req held -> grant sequence W,R,W,R... with writers alternating wr0,wr1 (wr0 first after reset); count stays 10/11.
- Flush: count=5, pulse flush -> no grants that cycle, then CLR_RD, CLR_WR; count=0, empty=1, busy high for 2 cycles.
- rst mid-read: rd_gnt in cycle N, rst in cycle N+1 -> rd_valid=0 at N+2, clear sequence restarts, count=0.
